fx_mst: RTL and testbench

FX_MST -- requirements
Module: fx_mst

---
 rtl/fx_mst.sv | 180 ++++++++++++++++++
 tb/tb_fx_mst.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_mst.sv
// Byte-command register master: opcode + 3 address bytes (+ data) -> fx_wr/fx_rd strobes, read data returned on rsp.
// Strobe 1 cycle after last byte; read data RD_LAT+1 cycles after fx_rd; cmd_rdy low from strobe until response taken, rsp held until rsp_rdy.
module fx_mst #(
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 1000
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    output logic [7:0]  rsp_data,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [21:0] fx_waddr,
    output logic [7:0]  fx_data,
    output logic        fx_wr,
    output logic [21:0] fx_raddr,
    output logic        fx_rd,
    input  logic [7:0]  fx_q,
    output logic [7:0]  err_cnt
);
    localparam logic [7:0]  OP_WR    = 8'h57;
    localparam logic [7:0]  OP_RD    = 8'h52;
    localparam logic [3:0]  LAT_LAST = 4'(RD_LAT);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADR2,
        S_ADR1,
        S_ADR0,
        S_DAT,
        S_WR,
        S_RD,
        S_WAIT,
        S_RSP
    } state_t;

    state_t      state_q, state_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        is_wr_q, is_wr_d;
    logic [21:0] addr_q, addr_d;
    logic [21:0] fx_waddr_q, fx_waddr_d;
    logic [7:0]  fx_data_q, fx_data_d;
    logic [21:0] fx_raddr_q, fx_raddr_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        cmd_acc;
    logic        bad_op;
    logic        timeout;

    assign cmd_acc = cmd_vld & cmd_rdy_q;

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        fx_waddr_d = fx_waddr_q;
        fx_data_d  = fx_data_q;
        fx_raddr_d = fx_raddr_q;
        rsp_data_d = rsp_data_q;
        err_cnt_d  = err_cnt_q;
        lat_cnt_d  = '0;
        tmo_cnt_d  = '0;
        bad_op     = 1'b0;
        timeout    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    if (cmd_data == OP_WR || cmd_data == OP_RD) begin
                        state_d = S_ADR2;
                        is_wr_d = (cmd_data == OP_WR);
                    end else begin
                        bad_op = 1'b1;
                    end
                end
            end
            S_ADR2, S_ADR1, S_ADR0, S_DAT: begin
                if (cmd_acc) begin
                    // 22-bit shift drops A2[7:6] once all three address bytes are in
                    if (state_q != S_DAT) begin
                        addr_d = {addr_q[13:0], cmd_data};
                    end
                    case (state_q)
                        S_ADR2: state_d = S_ADR1;
                        S_ADR1: state_d = S_ADR0;
                        S_ADR0: begin
                            if (is_wr_q) begin
                                state_d = S_DAT;
                            end else begin
                                state_d    = S_RD;
                                fx_raddr_d = {addr_q[13:0], cmd_data};
                            end
                        end
                        default: begin
                            state_d    = S_WR;
                            fx_waddr_d = addr_q;
                            fx_data_d  = cmd_data;
                        end
                    endcase
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    timeout = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            S_WR: state_d = S_IDLE;
            S_RD: begin
                state_d   = S_WAIT;
                lat_cnt_d = 4'd1;
            end
            S_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    rsp_data_d = fx_q;
                    state_d    = S_RSP;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            S_RSP: begin
                if (rsp_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((bad_op || timeout) && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        // Registered so cmd_rdy stays low through reset and rises on the first clock after it
        cmd_rdy_d = (state_d == S_IDLE) || (state_d == S_ADR2) || (state_d == S_ADR1) ||
                    (state_d == S_ADR0) || (state_d == S_DAT);
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cmd_rdy_q  <= 1'b0;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            fx_waddr_q <= '0;
            fx_data_q  <= '0;
            fx_raddr_q <= '0;
            rsp_data_q <= '0;
            err_cnt_q  <= '0;
            lat_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmd_rdy_q  <= cmd_rdy_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            fx_waddr_q <= fx_waddr_d;
            fx_data_q  <= fx_data_d;
            fx_raddr_q <= fx_raddr_d;
            rsp_data_q <= rsp_data_d;
            err_cnt_q  <= err_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign cmd_rdy  = cmd_rdy_q;
    assign fx_wr    = (state_q == S_WR);
    assign fx_rd    = (state_q == S_RD);
    assign rsp_vld  = (state_q == S_RSP);
    assign rsp_data = rsp_data_q;
    assign fx_waddr = fx_waddr_q;
    assign fx_data  = fx_data_q;
    assign fx_raddr = fx_raddr_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_fx_mst.sv
// Directed bench for fx_mst: write, read latency, back-pressure, errors/timeout, address masking, reset mid-read.
// Inputs change on the falling clock edge; outputs are sampled there too.
module tb_fx_mst;
    localparam int RD_LAT  = 2;
    localparam int TIMEOUT = 1000;

    logic        clk_sys = 1'b0;
    logic        rst     = 1'b1;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_vld  = 1'b0;
    logic        cmd_rdy;
    logic [7:0]  rsp_data;
    logic        rsp_vld;
    logic        rsp_rdy  = 1'b1;
    logic [21:0] fx_waddr;
    logic [7:0]  fx_data;
    logic        fx_wr;
    logic [21:0] fx_raddr;
    logic        fx_rd;
    logic [7:0]  fx_q;
    logic [7:0]  err_cnt;

    fx_mst #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .cmd_data (cmd_data),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .rsp_data (rsp_data),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .fx_waddr (fx_waddr),
        .fx_data  (fx_data),
        .fx_wr    (fx_wr),
        .fx_raddr (fx_raddr),
        .fx_rd    (fx_rd),
        .fx_q     (fx_q),
        .err_cnt  (err_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Responder: fx_q carries q_val exactly two cycles after fx_rd, junk otherwise
    logic [1:0] rd_pipe = 2'b00;
    logic [7:0] q_val   = 8'h00;
    always @(posedge clk_sys) rd_pipe <= {rd_pipe[0], fx_rd};
    assign fx_q = rd_pipe[1] ? q_val : 8'hEE;

    int   wr_pulses  = 0;
    int   rd_pulses  = 0;
    int   vld_rises  = 0;
    int   rsp_xfers  = 0;
    logic prev_wr    = 1'b0;
    logic prev_rd    = 1'b0;
    logic prev_vld   = 1'b0;
    logic strobe_bad = 1'b0;

    always @(negedge clk_sys) begin
        if (fx_wr) wr_pulses <= wr_pulses + 1;
        if (fx_rd) rd_pulses <= rd_pulses + 1;
        if (rsp_vld && !prev_vld) vld_rises <= vld_rises + 1;
        if (!rsp_vld && prev_vld) rsp_xfers <= rsp_xfers + 1;
        if ((fx_wr && fx_rd) || (fx_wr && prev_wr) || (fx_rd && prev_rd)) strobe_bad <= 1'b1;
        prev_wr  <= fx_wr;
        prev_rd  <= fx_rd;
        prev_vld <= rsp_vld;
    end

    // Starts and ends on a falling edge; returns in the cycle after the byte is accepted
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_data = b;
        cmd_vld  = 1'b1;
        while (cmd_rdy !== 1'b1 && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL send_byte_rdy_timeout: byte %h not accepted within %0d cycles", b, n);
        end
        @(negedge clk_sys);
        cmd_vld = 1'b0;
    endtask

    task automatic wait_rsp_vld(input string tag);
        int n;
        n = 0;
        while (rsp_vld !== 1'b1 && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (rsp_vld !== 1'b1) begin
            failures++;
            $display("FAIL %s: rsp_vld=%b after %0d cycles, want 1", tag, rsp_vld, n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        checks++;
        if (fx_wr !== 1'b0 || fx_rd !== 1'b0 || rsp_vld !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: wr=%b rd=%b vld=%b want 0 0 0", fx_wr, fx_rd, rsp_vld);
        end
        checks++;
        if (cmd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_cmd_rdy: got %b want 0", cmd_rdy);
        end
        checks++;
        if (err_cnt !== 8'h00) begin
            failures++;
            $display("FAIL reset_err_cnt: got %h want 00", err_cnt);
        end
        checks++;
        if (fx_waddr !== 22'h0 || fx_data !== 8'h00 || fx_raddr !== 22'h0 || rsp_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_regs: waddr=%h data=%h raddr=%h rsp=%h want all 0",
                     fx_waddr, fx_data, fx_raddr, rsp_data);
        end
        rst = 1'b0;
        checks++;
        if (cmd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL release_cmd_rdy_early: got %b want 0", cmd_rdy);
        end
        @(negedge clk_sys);
        checks++;
        if (cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL release_cmd_rdy: got %b want 1", cmd_rdy);
        end
    endtask

    task automatic test_write;
        int w0, v0;
        w0 = wr_pulses;
        v0 = vld_rises;
        rsp_rdy = 1'b1;
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h23);
        send_byte(8'hA5);
        checks++;
        if (fx_wr !== 1'b1 || fx_waddr !== 22'h000123 || fx_data !== 8'hA5) begin
            failures++;
            $display("FAIL write_strobe: wr=%b waddr=%h data=%h want 1 000123 a5", fx_wr, fx_waddr, fx_data);
        end
        checks++;
        if (cmd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL write_cmd_rdy_in_wr: got %b want 0", cmd_rdy);
        end
        @(negedge clk_sys);
        checks++;
        if (fx_wr !== 1'b0 || cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL write_after: wr=%b cmd_rdy=%b want 0 1", fx_wr, cmd_rdy);
        end
        repeat (4) @(negedge clk_sys);
        checks++;
        if (wr_pulses - w0 !== 1 || vld_rises - v0 !== 0) begin
            failures++;
            $display("FAIL write_counts: wr_pulses=%0d vld_rises=%0d want 1 0", wr_pulses - w0, vld_rises - v0);
        end
    endtask

    task automatic test_read;
        int r0, x0, rd_cyc;
        r0 = rd_pulses;
        x0 = rsp_xfers;
        q_val = 8'h5C;
        send_byte(8'h52);
        send_byte(8'h3F);
        send_byte(8'hFF);
        send_byte(8'hFE);
        rd_cyc = cyc;
        checks++;
        if (fx_rd !== 1'b1 || fx_raddr !== 22'h3FFFFE) begin
            failures++;
            $display("FAIL read_strobe: rd=%b raddr=%h want 1 3ffffe", fx_rd, fx_raddr);
        end
        checks++;
        if (fx_waddr !== 22'h000123 || fx_data !== 8'hA5) begin
            failures++;
            $display("FAIL read_keeps_write_regs: waddr=%h data=%h want 000123 a5", fx_waddr, fx_data);
        end
        @(negedge clk_sys);
        checks++;
        if (cmd_rdy !== 1'b0 || rsp_vld !== 1'b0) begin
            failures++;
            $display("FAIL read_wait: cmd_rdy=%b vld=%b want 0 0", cmd_rdy, rsp_vld);
        end
        wait_rsp_vld("read_vld_timeout");
        checks++;
        if (cyc - rd_cyc !== 3) begin
            failures++;
            $display("FAIL read_latency: rsp_vld rose %0d cycles after fx_rd, want 3", cyc - rd_cyc);
        end
        checks++;
        if (rsp_data !== 8'h5C) begin
            failures++;
            $display("FAIL read_data: got %h want 5c", rsp_data);
        end
        @(negedge clk_sys);
        checks++;
        if (rsp_vld !== 1'b0 || cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL read_done: vld=%b cmd_rdy=%b want 0 1", rsp_vld, cmd_rdy);
        end
        repeat (2) @(negedge clk_sys);
        checks++;
        if (rd_pulses - r0 !== 1 || rsp_xfers - x0 !== 1) begin
            failures++;
            $display("FAIL read_counts: rd_pulses=%0d xfers=%0d want 1 1", rd_pulses - r0, rsp_xfers - x0);
        end
    endtask

    task automatic test_back_pressure;
        int x0;
        x0 = rsp_xfers;
        q_val = 8'h3A;
        rsp_rdy = 1'b0;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h10);
        wait_rsp_vld("bp_vld_timeout");
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (rsp_vld !== 1'b1 || rsp_data !== 8'h3A || cmd_rdy !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold: cycle %0d vld=%b data=%h cmd_rdy=%b want 1 3a 0",
                         i, rsp_vld, rsp_data, cmd_rdy);
            end
            @(negedge clk_sys);
        end
        rsp_rdy = 1'b1;
        @(negedge clk_sys);
        checks++;
        if (rsp_vld !== 1'b0 || cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: vld=%b cmd_rdy=%b want 0 1", rsp_vld, cmd_rdy);
        end
        repeat (2) @(negedge clk_sys);
        checks++;
        if (rsp_xfers - x0 !== 1) begin
            failures++;
            $display("FAIL bp_xfers: got %0d want 1", rsp_xfers - x0);
        end
    endtask

    task automatic test_errors;
        int w0;
        logic [7:0] b;
        w0 = wr_pulses;
        checks++;
        if (err_cnt !== 8'h00) begin
            failures++;
            $display("FAIL err_start: got %h want 00", err_cnt);
        end
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h57);
        send_byte(8'h01);
        for (int i = 0; i < TIMEOUT - 1; i++) @(negedge clk_sys);
        checks++;
        if (err_cnt !== 8'h02) begin
            failures++;
            $display("FAIL err_before_timeout: got %h want 02", err_cnt);
        end
        @(negedge clk_sys);
        checks++;
        if (err_cnt !== 8'h03 || cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL err_timeout: err=%h cmd_rdy=%b want 03 1", err_cnt, cmd_rdy);
        end
        for (int i = 0; i < 300; i++) begin
            b = (i % 2 == 1) ? 8'hAA : 8'h00;
            send_byte(b);
            if (i == 0) begin
                checks++;
                if (err_cnt !== 8'h04) begin
                    failures++;
                    $display("FAIL err_idle_after_timeout: got %h want 04", err_cnt);
                end
            end
        end
        checks++;
        if (err_cnt !== 8'hFF) begin
            failures++;
            $display("FAIL err_saturate: got %h want ff", err_cnt);
        end
        repeat (2) @(negedge clk_sys);
        checks++;
        if (wr_pulses - w0 !== 0) begin
            failures++;
            $display("FAIL err_no_write: wr_pulses=%0d want 0", wr_pulses - w0);
        end
    endtask

    task automatic test_addr_mask;
        q_val = 8'h11;
        send_byte(8'h52);
        send_byte(8'hC1);
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if (fx_rd !== 1'b1 || fx_raddr !== 22'h010000) begin
            failures++;
            $display("FAIL addr_mask: rd=%b raddr=%h want 1 010000", fx_rd, fx_raddr);
        end
        wait_rsp_vld("addr_mask_vld_timeout");
        @(negedge clk_sys);
    endtask

    task automatic test_reset_mid_read;
        int r0, v0;
        r0 = rd_pulses;
        v0 = vld_rises;
        q_val = 8'h77;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h05);
        @(negedge clk_sys);
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_vld !== 1'b0 || err_cnt !== 8'h00 || cmd_rdy !== 1'b0 || fx_raddr !== 22'h0) begin
            failures++;
            $display("FAIL mid_reset_state: vld=%b err=%h cmd_rdy=%b raddr=%h want 0 00 0 0",
                     rsp_vld, err_cnt, cmd_rdy, fx_raddr);
        end
        @(negedge clk_sys);
        rst = 1'b0;
        repeat (8) @(negedge clk_sys);
        checks++;
        if (vld_rises - v0 !== 0 || rd_pulses - r0 !== 1) begin
            failures++;
            $display("FAIL mid_reset_dropped: vld_rises=%0d rd_pulses=%0d want 0 1", vld_rises - v0, rd_pulses - r0);
        end
        send_byte(8'h57);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h5A);
        checks++;
        if (fx_wr !== 1'b1 || fx_waddr !== 22'h010203 || fx_data !== 8'h5A) begin
            failures++;
            $display("FAIL mid_reset_write: wr=%b waddr=%h data=%h want 1 010203 5a", fx_wr, fx_waddr, fx_data);
        end
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_strobe_rules;
        checks++;
        if (strobe_bad !== 1'b0) begin
            failures++;
            $display("FAIL strobe_rules: overlapping or stretched strobe seen=%b want 0", strobe_bad);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_pressure();
        test_errors();
        test_addr_mask();
        test_reset_mid_read();
        test_strobe_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
